mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single 128-bit port of the on-chip data memory between two requesters: the 32-bit system bus (byte-masked word accesses) and the accelerator interface (full 128-bit lines, with read bursts).
- Arbitrates between the two requesters round-robin.
- Maps system-bus words onto line lanes.
- Sequences interface read bursts.
- Returns read data to the requester that issued the read.

Parameters:
MEM_AW, 10, memory line-address width (lines of 16 bytes)
RD_LAT, 1, memory read latency in cycles from mem_en to mem_rdata valid (legal 1..3)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
sb_req_valid  in  1  system-bus request valid
sb_req_ready  out  1  system-bus request accepted (valid & ready at posedge)
sb_we  in  1  1 = write, 0 = read
sb_addr  in  32  byte address
sb_mask  in  4  byte-write mask (writes only)
sb_wdata  in  32  write data
sb_rsp_valid  out  1  read data valid (one-cycle pulse)
sb_rdata  out  32  read data
if_req_valid  in  1  interface request valid
if_req_ready  out  1  interface request accepted
if_we  in  1  1 = write, 0 = read
if_addr  in  32  byte address (line aligned)
if_len  in  4  read burst length minus 1 (0 = single line)
if_wdata  in  128  write line
if_rsp_valid  out  1  read beat valid
if_rsp_last  out  1  final beat of burst
if_rdata  out  128  read line
mem_en  out  1  memory enable
mem_we  out  16  per-byte write strobe
mem_addr  out  MEM_AW  line address
mem_wdata  out  128  write line
mem_rdata  in  128  read line

Behaviour:
- Reset (async, active-high):
  - All outputs are 0; sb_req_ready and if_req_ready are low.
  - FSM returns to IDLE and the response pipeline is flushed.
  - last_grant = IF, so SB wins the first tie.
- FSM states:
  - IDLE: requests are accepted.
  - BURST: issues beats 2..N of an interface read burst.
- IDLE grant:
  - One requester granted per cycle.
  - If only one is valid, it is granted.
  - If both are valid, the one not in last_grant wins.
  - Ready is combinational from valid and state; ready is low in BURST.
  - An accepted request updates last_grant.
- Command timing: an accept at edge T registers the memory command; mem_en is visible in cycle T+1. With no accept, mem_en = 0 and mem_we = 0.
- SB mapping:
  - lane = sb_addr[3:2]; sb_addr[1:0] ignored.
  - mem_addr = sb_addr[MEM_AW+3:4].
  - mem_wdata = sb_wdata replicated into all 4 lanes.
  - mem_we = sb_mask << 4*lane for writes, 0 for reads.
  - sb_rdata = 32-bit lane `lane` of mem_rdata.
- IF mapping:
  - mem_addr = if_addr[MEM_AW+3:4]; if_addr[3:0] ignored.
  - Writes use mem_we = 16'hFFFF and are single-beat; if_len is ignored for writes.
- Burst read (if_we = 0, if_len = L > 0):
  - The accept issues beat 0 and the FSM enters BURST.
  - BURST issues beats 1..L on consecutive cycles at mem_addr+1, mem_addr+2, … .
  - The line address wraps modulo 2^MEM_AW.
  - The FSM returns to IDLE in the cycle after the last beat is issued; last_grant = IF.
  - Bursts are not preemptible; SB waits.
- Read response:
  - A tag pipeline of RD_LAT+1 stages carries {valid, owner, lane, last}.
  - rsp_valid and rdata are registered; they are visible in cycle T+2+RD_LAT for an issue accepted/scheduled at edge T.
  - Responses are returned in issue order with no backpressure.
  - Writes produce no response.
  - if_rsp_last is high only with the final beat; single reads have last = 1.
- Simultaneous events: a request arriving in the same cycle the burst ends is not accepted until IDLE (the next cycle).
- Reset mid-burst: the remaining beats are dropped and in-flight responses are discarded; no rsp_valid appears after reset is released until new reads complete.

Decomposition:
- Package mem_arb_pkg:
  - typedef owner_e {OWN_SB, OWN_IF}
  - typedef state_e {IDLE, BURST}
  - struct rsp_tag_t {valid, owner, lane[1:0], last}
  - constants LINE_BYTES = 16, LANES = 4
- Sub-module rsp_tag_pipe: RD_LAT+1 deep shift register of rsp_tag_t with async clear.

Test Plan:
1. SB write 0x14, mask 4'b0011, data 0xDEADBEEF → mem_addr 1, mem_we 16'h0030, mem_wdata = 0xDEADBEEF ×4. Then SB read 0x14 with line initialised to 0 → sb_rdata 0x0000BEEF.
2. After reset, both requesters valid continuously with single reads → grants alternate SB, IF, SB, IF; both ready never high in the same cycle.
3. IF read 0x100, if_len 3 → mem_addr 0x10..0x13 on 4 consecutive cycles; 4 if_rsp_valid pulses, if_rsp_last on the 4th. An SB request raised during the burst is accepted the cycle after BURST exits.
4. RD_LAT = 2, SB read accepted at edge T → sb_rsp_valid high exactly in cycle T+4 for one cycle.
5. Assert rst after beat 1 of a len-7 burst → all outputs 0 immediately; no rsp_valid after release. A following SB read at 0x0 completes normally.
6. IF write 0x20, if_len 5, if_wdata pattern → a single beat: mem_addr 2, mem_we 16'hFFFF, no if_rsp_valid.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the data-memory port arbiter.
// Tags travel alongside memory reads so each returning line can be routed back.
package mem_arb_pkg;

    localparam int LINE_BYTES = 16;
    localparam int LANES      = 4;

    typedef enum logic {
        OWN_SB = 1'b0,
        OWN_IF = 1'b1
    } owner_e;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    typedef struct packed {
        logic       valid;
        owner_e     owner;
        logic [1:0] lane;
        logic       last;
    } rsp_tag_t;

    function automatic logic [31:0] lane_word(input logic [127:0] line, input logic [1:0] lane);
        return line[32*lane +: 32];
    endfunction

    function automatic logic [15:0] lane_strobe(input logic [3:0] mask, input logic [1:0] lane);
        return {12'b0, mask} << {lane, 2'b00};
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rsp_tag_pipe.sv
// Delay line for read tags; the last stage lines up with mem_rdata.
// Async clear drops every in-flight read on reset.
module rsp_tag_pipe
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst,
    input  rsp_tag_t tag_in,
    output rsp_tag_t tag_out
);

    rsp_tag_t stage [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one 128-bit memory port between the 32-bit
// system bus and the accelerator line interface (with read bursts).
//
// state    | meaning
// ST_IDLE  | accept one request per cycle, round-robin on ties
// ST_BURST | issue remaining beats of an interface read burst; ready held low
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_AW = 10,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              sb_req_valid,
    output logic              sb_req_ready,
    input  logic              sb_we,
    input  logic [31:0]       sb_addr,
    input  logic [3:0]        sb_mask,
    input  logic [31:0]       sb_wdata,
    output logic              sb_rsp_valid,
    output logic [31:0]       sb_rdata,

    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic              if_we,
    input  logic [31:0]       if_addr,
    input  logic [3:0]        if_len,
    input  logic [127:0]      if_wdata,
    output logic              if_rsp_valid,
    output logic              if_rsp_last,
    output logic [127:0]      if_rdata,

    output logic              mem_en,
    output logic [15:0]       mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [127:0]      mem_wdata,
    input  logic [127:0]      mem_rdata
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    logic [0:0]        state;
    owner_e            last_grant;
    logic [3:0]        beats_left;
    logic [MEM_AW-1:0] burst_addr;

    logic              in_idle;
    logic              sb_win;
    logic              if_win;

    logic              cmd_en;
    logic [15:0]       cmd_we;
    logic [MEM_AW-1:0] cmd_addr;
    logic [127:0]      cmd_wdata;
    rsp_tag_t          tag_in;
    rsp_tag_t          tag_out;

    logic              sb_hit;
    logic              if_hit;

    logic              unused_addr_bits;
    assign unused_addr_bits = ^{sb_addr[31:MEM_AW+4], sb_addr[1:0],
                                if_addr[31:MEM_AW+4], if_addr[3:0]};

    // Ready must read low while reset is held even though the state is already IDLE.
    assign in_idle = !rst && (state == ST_IDLE);
    assign sb_win  = sb_req_valid && (!if_req_valid || last_grant == OWN_IF);
    assign if_win  = if_req_valid && (!sb_req_valid || last_grant == OWN_SB);

    assign sb_req_ready = in_idle && sb_win;
    assign if_req_ready = in_idle && if_win;

    always_comb begin
        cmd_en    = 1'b0;
        cmd_we    = '0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        tag_in    = '0;
        if (sb_req_ready) begin
            cmd_en       = 1'b1;
            cmd_addr     = sb_addr[MEM_AW+3:4];
            cmd_wdata    = {LANES{sb_wdata}};
            cmd_we       = sb_we ? lane_strobe(sb_mask, sb_addr[3:2]) : 16'h0000;
            tag_in.valid = !sb_we;
            tag_in.owner = OWN_SB;
            tag_in.lane  = sb_addr[3:2];
            tag_in.last  = 1'b1;
        end else if (if_req_ready) begin
            cmd_en       = 1'b1;
            cmd_addr     = if_addr[MEM_AW+3:4];
            cmd_wdata    = if_wdata;
            cmd_we       = if_we ? 16'hFFFF : 16'h0000;
            tag_in.valid = !if_we;
            tag_in.owner = OWN_IF;
            tag_in.last  = if_we || (if_len == 4'd0);
        end else if (state == ST_BURST) begin
            cmd_en       = 1'b1;
            cmd_addr     = burst_addr;
            tag_in.valid = 1'b1;
            tag_in.owner = OWN_IF;
            tag_in.last  = (beats_left == 4'd1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_grant <= OWN_IF;
            beats_left <= '0;
            burst_addr <= '0;
            mem_en     <= 1'b0;
            mem_we     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            mem_en    <= cmd_en;
            mem_we    <= cmd_we;
            mem_addr  <= cmd_addr;
            mem_wdata <= cmd_wdata;

            if (sb_req_ready) begin
                last_grant <= OWN_SB;
            end else if (if_req_ready) begin
                last_grant <= OWN_IF;
            end

            case (state)
                ST_IDLE: begin
                    if (if_req_ready && !if_we && (if_len != 4'd0)) begin
                        state      <= ST_BURST;
                        beats_left <= if_len;
                        burst_addr <= if_addr[MEM_AW+3:4] + 1'b1;
                    end
                end
                ST_BURST: begin
                    // Line address wraps naturally at the top of memory.
                    burst_addr <= burst_addr + 1'b1;
                    beats_left <= beats_left - 4'd1;
                    if (beats_left == 4'd1) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    rsp_tag_pipe #(
        .DEPTH (RD_LAT + 1)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    assign sb_hit = tag_out.valid && (tag_out.owner == OWN_SB);
    assign if_hit = tag_out.valid && (tag_out.owner == OWN_IF);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_rsp_valid <= 1'b0;
            sb_rdata     <= '0;
            if_rsp_valid <= 1'b0;
            if_rsp_last  <= 1'b0;
            if_rdata     <= '0;
        end else begin
            sb_rsp_valid <= sb_hit;
            if_rsp_valid <= if_hit;
            if_rsp_last  <= if_hit && tag_out.last;
            if (sb_hit) begin
                sb_rdata <= lane_word(mem_rdata, tag_out.lane);
            end
            if (if_hit) begin
                if_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small synchronous memory model.
module tb_mem_port_arbiter;

    localparam int MEM_AW = 10;
    localparam int RD_LAT = 2;

    logic              clk;
    logic              rst;
    logic              sb_req_valid;
    logic              sb_req_ready;
    logic              sb_we;
    logic [31:0]       sb_addr;
    logic [3:0]        sb_mask;
    logic [31:0]       sb_wdata;
    logic              sb_rsp_valid;
    logic [31:0]       sb_rdata;
    logic              if_req_valid;
    logic              if_req_ready;
    logic              if_we;
    logic [31:0]       if_addr;
    logic [3:0]        if_len;
    logic [127:0]      if_wdata;
    logic              if_rsp_valid;
    logic              if_rsp_last;
    logic [127:0]      if_rdata;
    logic              mem_en;
    logic [15:0]       mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [127:0]      mem_wdata;
    logic [127:0]      mem_rdata;

    mem_port_arbiter #(
        .MEM_AW (MEM_AW),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sb_req_valid (sb_req_valid),
        .sb_req_ready (sb_req_ready),
        .sb_we        (sb_we),
        .sb_addr      (sb_addr),
        .sb_mask      (sb_mask),
        .sb_wdata     (sb_wdata),
        .sb_rsp_valid (sb_rsp_valid),
        .sb_rdata     (sb_rdata),
        .if_req_valid (if_req_valid),
        .if_req_ready (if_req_ready),
        .if_we        (if_we),
        .if_addr      (if_addr),
        .if_len       (if_len),
        .if_wdata     (if_wdata),
        .if_rsp_valid (if_rsp_valid),
        .if_rsp_last  (if_rsp_last),
        .if_rdata     (if_rdata),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: read-before-write, data valid RD_LAT cycles after mem_en.
    localparam logic [127:0] LINE0  = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] LINE4  = 128'h44440003_44440002_44440001_44440000;
    localparam logic [127:0] LINE20 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    localparam logic [127:0] WPAT   = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;

    logic [127:0] mem_arr [1 << MEM_AW];
    logic [127:0] rd_q [RD_LAT];
    logic         mem_loaded = 1'b0;

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < (1 << MEM_AW); i++) begin
                mem_arr[i] <= '0;
            end
            mem_arr[0]     <= LINE0;
            mem_arr[4]     <= LINE4;
            mem_arr[32]    <= LINE20;
            mem_arr[1022]  <= {4{32'hFE000000}};
            mem_arr[1023]  <= {4{32'hFF000000}};
            for (int i = 0; i < 4; i++) begin
                mem_arr[16 + i] <= {4{32'hC0DE0000 + 32'(i)}};
            end
            mem_loaded <= 1'b1;
        end else if (mem_en) begin
            rd_q[0] <= mem_arr[mem_addr];
            for (int b = 0; b < 16; b++) begin
                if (mem_we[b]) begin
                    mem_arr[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
        for (int i = 1; i < RD_LAT; i++) begin
            rd_q[i] <= rd_q[i-1];
        end
    end
    assign mem_rdata = rd_q[RD_LAT-1];

    // Response monitor, sampled on the falling edge.
    int           sb_cnt;
    int           if_cnt;
    logic [31:0]  sb_last;
    logic [127:0] if_beats [8];
    logic [7:0]   if_lasts;
    logic         mon_clr;

    always @(negedge clk) begin
        if (mon_clr) begin
            sb_cnt   = 0;
            if_cnt   = 0;
            sb_last  = '0;
            if_lasts = '0;
        end else begin
            if (sb_rsp_valid) begin
                sb_last = sb_rdata;
                sb_cnt++;
            end
            if (if_rsp_valid) begin
                if (if_cnt < 8) begin
                    if_beats[if_cnt] = if_rdata;
                    if_lasts[if_cnt] = if_rsp_last;
                end
                if_cnt++;
            end
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic mon_clear();
        mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Called in the cycle right after the accept edge; k=1 there.
    task automatic wait_sb(output int k);
        k = 1;
        while (!sb_rsp_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    int           k;
    logic [31:0]  w;
    logic [127:0] exp_line;

    initial begin
        rst = 1'b1;
        mon_clr = 1'b0;
        sb_req_valid = 1'b1; sb_we = 1'b0; sb_addr = '0; sb_mask = '0; sb_wdata = '0;
        if_req_valid = 1'b0; if_we = 1'b0; if_addr = '0; if_len = '0; if_wdata = '0;
        repeat (3) @(negedge clk);
        #1 check_val("rst_outputs", 128'(|{sb_req_ready, if_req_ready, sb_rsp_valid, sb_rdata,
                                             if_rsp_valid, if_rsp_last, if_rdata, mem_en, mem_we,
                                             mem_addr, mem_wdata}), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        sb_req_valid = 1'b0;
        @(negedge clk);

        // SB masked writes and a lane read
        sb_req_valid = 1'b1; sb_we = 1'b1; sb_addr = 32'h14; sb_mask = 4'b0011; sb_wdata = 32'hDEADBEEF;
        #1 check_val("t1_wr_ready", 128'(sb_req_ready), 128'(1));
        @(negedge clk);
        check_val("t1_wr_en", 128'(mem_en), 128'(1));
        check_val("t1_wr_addr", 128'(mem_addr), 128'(1));
        check_val("t1_wr_we", 128'(mem_we), 128'(16'h0030));
        check_val("t1_wr_data", mem_wdata, {4{32'hDEADBEEF}});
        sb_addr = 32'h3C; sb_mask = 4'b1001; sb_wdata = 32'h0BADF00D;
        @(negedge clk);
        check_val("t1_lane3_addr", 128'(mem_addr), 128'(3));
        check_val("t1_lane3_we", 128'(mem_we), 128'(16'h9000));
        sb_we = 1'b0; sb_addr = 32'h16;
        @(negedge clk);
        check_val("t1_rd_en", 128'(mem_en), 128'(1));
        check_val("t1_rd_we", 128'(mem_we), 128'(0));
        check_val("t1_rd_addr", 128'(mem_addr), 128'(1));
        sb_req_valid = 1'b0;
        wait_sb(k);
        check_val("t4_rd_latency", 128'(k), 128'(RD_LAT + 2));
        check_val("t1_rd_data", 128'(sb_rdata), 128'(32'h0000BEEF));
        @(negedge clk);
        check_val("t4_rsp_pulse", 128'(sb_rsp_valid), 128'(0));
        check_val("t1_idle_en", 128'(mem_en), 128'(0));

        // Round-robin with both requesters valid
        do_reset();
        mon_clear();
        sb_req_valid = 1'b1; sb_we = 1'b0; sb_addr = 32'h0;
        if_req_valid = 1'b1; if_we = 1'b0; if_addr = 32'h200; if_len = 4'd0;
        for (int i = 0; i < 4; i++) begin
            #1 check_val($sformatf("t2_grant%0d", i), 128'({sb_req_ready, if_req_ready}),
                         128'((i % 2 == 0) ? 2'b10 : 2'b01));
            @(negedge clk);
        end
        sb_req_valid = 1'b0; if_req_valid = 1'b0;
        repeat (8) @(negedge clk);
        check_val("t2_sb_cnt", 128'(sb_cnt), 128'(2));
        check_val("t2_if_cnt", 128'(if_cnt), 128'(2));
        check_val("t2_sb_data", 128'(sb_last), 128'(32'h11111111));
        check_val("t2_if_data", if_beats[1], LINE20);
        check_val("t2_if_last", 128'(if_lasts[1:0]), 128'(2'b11));

        // IF read burst of four lines, SB waiting behind it
        mon_clear();
        if_req_valid = 1'b1; if_we = 1'b0; if_addr = 32'h100; if_len = 4'd3;
        #1 check_val("t3_if_ready", 128'(if_req_ready), 128'(1));
        @(negedge clk);
        check_val("t3_beat0_addr", 128'(mem_addr), 128'(10'h10));
        if_req_valid = 1'b0;
        sb_req_valid = 1'b1; sb_we = 1'b0; sb_addr = 32'h48;
        #1 check_val("t3_sb_blocked", 128'(sb_req_ready), 128'(0));
        for (int j = 1; j <= 3; j++) begin
            @(negedge clk);
            check_val($sformatf("t3_beat%0d_addr", j), 128'({mem_en, mem_we, mem_addr}),
                      128'({1'b1, 16'h0000, 10'(16 + j)}));
            #1 check_val($sformatf("t3_sb_ready%0d", j), 128'(sb_req_ready), 128'(j == 3));
        end
        @(negedge clk);
        check_val("t3_sb_after_burst", 128'(mem_addr), 128'(4));
        sb_req_valid = 1'b0;
        repeat (8) @(negedge clk);
        check_val("t3_if_cnt", 128'(if_cnt), 128'(4));
        for (int i = 0; i < 4; i++) begin
            w = 32'hC0DE0000 + 32'(i);
            exp_line = {4{w}};
            check_val($sformatf("t3_beat%0d_data", i), if_beats[i], exp_line);
        end
        check_val("t3_last_mask", 128'(if_lasts[3:0]), 128'(4'b1000));
        check_val("t3_sb_cnt", 128'(sb_cnt), 128'(1));
        check_val("t3_sb_data", 128'(sb_last), 128'(32'h44440002));

        // Reset in the middle of a long burst
        mon_clear();
        if_req_valid = 1'b1; if_we = 1'b0; if_addr = 32'h0; if_len = 4'd7;
        @(negedge clk);
        check_val("t5_beat0_addr", 128'(mem_addr), 128'(0));
        if_req_valid = 1'b0;
        @(negedge clk);
        check_val("t5_beat1_addr", 128'(mem_addr), 128'(1));
        rst = 1'b1;
        #1 check_val("t5_rst_outputs", 128'(|{sb_req_ready, if_req_ready, sb_rsp_valid, sb_rdata,
                                                if_rsp_valid, if_rsp_last, if_rdata, mem_en, mem_we,
                                                mem_addr, mem_wdata}), 128'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check_val("t5_no_rsp", 128'({sb_cnt[7:0], if_cnt[7:0]}), 128'(0));
        check_val("t5_no_beats", 128'(mem_en), 128'(0));
        sb_req_valid = 1'b1; sb_we = 1'b0; sb_addr = 32'h0;
        @(negedge clk);
        sb_req_valid = 1'b0;
        wait_sb(k);
        check_val("t5_sb_latency", 128'(k), 128'(RD_LAT + 2));
        check_val("t5_sb_data", 128'(sb_rdata), 128'(32'h11111111));

        // IF write ignores if_len
        mon_clear();
        if_req_valid = 1'b1; if_we = 1'b1; if_addr = 32'h20; if_len = 4'd5; if_wdata = WPAT;
        #1 check_val("t6_if_ready", 128'(if_req_ready), 128'(1));
        @(negedge clk);
        check_val("t6_wr_cmd", 128'({mem_en, mem_we, mem_addr}), 128'({1'b1, 16'hFFFF, 10'd2}));
        check_val("t6_wr_data", mem_wdata, WPAT);
        if_req_valid = 1'b0;
        @(negedge clk);
        check_val("t6_single_beat", 128'(mem_en), 128'(0));
        repeat (8) @(negedge clk);
        check_val("t6_no_rsp", 128'(if_cnt), 128'(0));

        // Burst wrapping past the top line
        mon_clear();
        if_req_valid = 1'b1; if_we = 1'b0; if_addr = 32'h3FE0; if_len = 4'd2;
        @(negedge clk);
        check_val("t7_addr0", 128'(mem_addr), 128'(10'h3FE));
        if_req_valid = 1'b0;
        @(negedge clk);
        check_val("t7_addr1", 128'(mem_addr), 128'(10'h3FF));
        @(negedge clk);
        check_val("t7_addr_wrap", 128'({mem_en, mem_addr}), 128'({1'b1, 10'h000}));
        @(negedge clk);
        check_val("t7_burst_done", 128'(mem_en), 128'(0));
        repeat (8) @(negedge clk);
        check_val("t7_if_cnt", 128'(if_cnt), 128'(3));
        check_val("t7_wrap_data", if_beats[2], LINE0);
        check_val("t7_last_mask", 128'(if_lasts[2:0]), 128'(3'b100));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
